// File: rtl/vlane_pkg.sv
// Shared types for the vector lane: opcodes, FSM states and the pipeline stage record.
package vlane_pkg;

    localparam int unsigned def_vlen   = 8;
    localparam int unsigned def_vdw    = 8;
    localparam int unsigned def_lanes  = 4;
    localparam int unsigned def_opw    = 4;
    localparam int unsigned def_addr_w = $clog2(def_vlen);

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_FMA   = 4'b0011,
        OP_LOAD  = 4'b1000,
        OP_STORE = 4'b1001
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Stage widths follow the package defaults; the lane parameters must match them.
    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [def_addr_w-1:0] addr;
        logic [def_vdw-1:0]    data;
        logic [def_opw-1:0]    op;
    } stage_t;

    function automatic logic is_nop(input logic [def_opw-1:0] op);
        return op[3] && (op[2:1] != 2'b00);
    endfunction

endpackage

// File: rtl/vlane_alu.sv
// Combinational element ALU: add, sub, and, multiply-add, all modulo 2^vdw_p.
module vlane_alu
    import vlane_pkg::*;
#(
    parameter int unsigned vdw_p = def_vdw
) (
    input  logic [1:0]       fn,
    input  logic [vdw_p-1:0] a,
    input  logic [vdw_p-1:0] b,
    input  logic [vdw_p-1:0] c,
    output logic [vdw_p-1:0] y
);

    // NOTE: assign a default first in combinational blocks so no path leaves y unassigned (no latch).
    always_comb begin
        y = '0;
        case (fn)
            2'b00:   y = a + b;
            2'b01:   y = a - b;
            2'b10:   y = a & b;
            default: y = a * b + c;  // low product bits depend only on low operand bits
        endcase
    end

endmodule

// File: rtl/vlane.sv
// One slice of the vector unit: sequences this lane's elements through ISSUE/EX/WB.
// Optional element masking is enabled by defining VLANE_MASK_EN.
module vlane
    import vlane_pkg::*;
#(
    parameter int unsigned vlen_p     = def_vlen,
    parameter int unsigned vdw_p      = def_vdw,
    parameter int unsigned lanes_p    = def_lanes,
    parameter int unsigned op_width_p = def_opw,
    localparam int unsigned epl_lp    = vlen_p / lanes_p,
    localparam int unsigned addr_w_lp = $clog2(vlen_p),
    localparam int unsigned vl_w_lp   = $clog2(vlen_p + 1),
    localparam int unsigned id_w_lp   = $clog2(lanes_p),
    localparam int unsigned cnt_w_lp  = $clog2(epl_lp + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [id_w_lp-1:0]    my_id_i,
    input  logic                  start_v_i,
    output logic                  ready_o,
    input  logic [op_width_p-1:0] op_i,
    input  logic [vl_w_lp-1:0]    vl_i,
    input  logic [vdw_p-1:0]      scalar_i,
`ifdef VLANE_MASK_EN
    input  logic [epl_lp-1:0]     mask_i,
`endif
    input  logic [vdw_p-1:0]      w_data_i,
    input  logic                  w_v_i,
    output logic [vdw_p-1:0]      r_data_o,
    output logic                  r_v_o,
    input  logic                  r_ready_i,
    output logic                  done_o,
    output logic [addr_w_lp-1:0]  r_addr_o,
    input  logic [vdw_p-1:0]      r0_data_i,
    input  logic [vdw_p-1:0]      r1_data_i,
    input  logic [vdw_p-1:0]      r2_data_i,
    output logic [addr_w_lp-1:0]  w_addr_o,
    output logic [vdw_p-1:0]      w_data_o,
    output logic                  w_en_o
);

    state_e                state_q;
    logic [cnt_w_lp-1:0]   k_q, cnt_q, cnt_new;
    logic [op_width_p-1:0] op_q;
    logic [vdw_p-1:0]      scalar_q;
    logic [vl_w_lp-1:0]    vl_clamp;
    logic [addr_w_lp-1:0]  issue_addr;
    logic [vdw_p-1:0]      ex_b_q, ex_c_q, alu_y;
    stage_t                ex_q, wb_q;
    logic                  start_acc, is_load, is_store, elem_active, issue_go, last_elem;

    assign start_acc = start_v_i && (state_q == ST_IDLE);
    assign is_load   = (op_q == OP_LOAD);
    assign is_store  = (op_q == OP_STORE);

    // Elements owned by this lane: ceil((vl - id) / lanes), zero when id is past the end.
    always_comb begin
        vl_clamp = (vl_i > vl_w_lp'(vlen_p)) ? vl_w_lp'(vlen_p) : vl_i;
        cnt_new  = '0;
        if (vl_clamp > vl_w_lp'(my_id_i))
            cnt_new = cnt_w_lp'((vl_clamp - vl_w_lp'(my_id_i) + vl_w_lp'(lanes_p - 1)) >> id_w_lp);
    end

`ifdef VLANE_MASK_EN
    logic [epl_lp-1:0] mask_q, mask_sh;

    always_ff @(posedge clk_i) begin
        if (start_acc)
            mask_q <= mask_i;
    end

    assign mask_sh     = mask_q >> k_q;
    assign elem_active = mask_sh[0];
`else
    assign elem_active = 1'b1;
`endif

    assign issue_addr = (addr_w_lp'(k_q) << id_w_lp) | addr_w_lp'(my_id_i);
    assign last_elem  = (k_q == cnt_q - cnt_w_lp'(1));

    // A masked store element is skipped without waiting on the consumer.
    always_comb begin
        issue_go = 1'b0;
        if (state_q == ST_ISSUE) begin
            if (is_load)
                issue_go = w_v_i;
            else if (is_store)
                issue_go = elem_active ? r_ready_i : 1'b1;
            else
                issue_go = 1'b1;
        end
    end

    vlane_alu #(.vdw_p(vdw_p)) u_alu (
        .fn (ex_q.op[1:0]),
        .a  (ex_q.data),
        .b  (ex_b_q),
        .c  (ex_c_q),
        .y  (alu_y)
    );

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            // NOTE: only control state is reset; operand and data registers are qualified by valid.
            state_q    <= ST_IDLE;
            k_q        <= '0;
            ex_q.valid <= 1'b0;
            wb_q.valid <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_acc) begin
                        op_q     <= op_i;
                        scalar_q <= scalar_i;
                        cnt_q    <= cnt_new;
                        k_q      <= '0;
                        state_q  <= (cnt_new == '0 || is_nop(op_i)) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_go) begin
                        if (last_elem)
                            state_q <= ST_DRAIN;
                        else
                            k_q <= k_q + cnt_w_lp'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!ex_q.valid)
                        state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase

            ex_q.valid <= issue_go;
            if (issue_go) begin
                ex_q.wen  <= elem_active;
                ex_q.addr <= issue_addr;
                ex_q.op   <= op_q;
                ex_q.data <= is_load ? w_data_i : r0_data_i;
                ex_b_q    <= op_q[2] ? scalar_q : r1_data_i;
                ex_c_q    <= r2_data_i;
            end

            wb_q.valid <= ex_q.valid;
            wb_q.wen   <= ex_q.wen;
            wb_q.addr  <= ex_q.addr;
            wb_q.op    <= ex_q.op;
            wb_q.data  <= (ex_q.op == OP_LOAD) ? ex_q.data : alu_y;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign r_addr_o = issue_addr;
    assign r_data_o = r0_data_i;
    assign r_v_o    = (state_q == ST_ISSUE) && is_store && elem_active;
    assign w_addr_o = wb_q.addr;
    assign w_data_o = wb_q.data;
    assign w_en_o   = wb_q.valid && wb_q.wen && (wb_q.op != OP_STORE);

endmodule

// File: tb/tb_vlane.sv
// Directed bench for vlane: table of single-op vectors plus reset-during-issue sequences.
module tb_vlane;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic [1:0] my_id_i;
    logic       start_v_i;
    logic       ready_o;
    logic [3:0] op_i;
    logic [3:0] vl_i;
    logic [7:0] scalar_i;
    logic [1:0] mask_i;
    logic [7:0] w_data_i;
    logic       w_v_i;
    logic [7:0] r_data_o;
    logic       r_v_o;
    logic       r_ready_i;
    logic       done_o;
    logic [2:0] r_addr_o;
    logic [7:0] r0_data_i, r1_data_i, r2_data_i;
    logic [2:0] w_addr_o;
    logic [7:0] w_data_o;
    logic       w_en_o;

    always #5 clk_i = ~clk_i;

    vlane dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .my_id_i   (my_id_i),
        .start_v_i (start_v_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .vl_i      (vl_i),
        .scalar_i  (scalar_i),
`ifdef VLANE_MASK_EN
        .mask_i    (mask_i),
`endif
        .w_data_i  (w_data_i),
        .w_v_i     (w_v_i),
        .r_data_o  (r_data_o),
        .r_v_o     (r_v_o),
        .r_ready_i (r_ready_i),
        .done_o    (done_o),
        .r_addr_o  (r_addr_o),
        .r0_data_i (r0_data_i),
        .r1_data_i (r1_data_i),
        .r2_data_i (r2_data_i),
        .w_addr_o  (w_addr_o),
        .w_data_o  (w_data_o),
        .w_en_o    (w_en_o)
    );

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [1:0] id;
        logic [3:0] vl;
        logic [7:0] sc, r0, r1, r2;
        logic [31:0] wv, rr;     // per-cycle w_v_i / r_ready_i, bit n = cycle n
        logic [1:0] mask;
        int         hold;        // extra cycles start_v_i stays high after accept
        int         e_nwr;
        int         e_c0;
        logic [2:0] e_a0;
        logic [7:0] e_d0;
        int         e_c1;
        logic [2:0] e_a1;
        logic [7:0] e_d1;
        int         e_done;
        int         e_nx;
        logic [2:0] e_xa;
        logic [7:0] e_xd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n_wr, n_x, n_done, done_cyc, wv_cnt;
        int wr_c[2];
        logic [2:0] wr_a[2];
        logic [7:0] wr_d[2];
        logic [2:0] x_a;
        logic [7:0] x_d;
        n_wr = 0; n_x = 0; n_done = 0; done_cyc = -1; wv_cnt = 0;
        x_a = '0; x_d = '0;
        for (int i = 0; i < 2; i++) begin
            wr_c[i] = -1; wr_a[i] = '0; wr_d[i] = '0;
        end
        @(posedge clk_i); #1;
        my_id_i = v.id; op_i = v.op; vl_i = v.vl; scalar_i = v.sc; mask_i = v.mask;
        r0_data_i = v.r0; r1_data_i = v.r1; r2_data_i = v.r2;
        w_v_i = v.wv[0]; r_ready_i = v.rr[0]; w_data_i = 8'hAA;
        start_v_i = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk_i);
            if (cyc == 0) check({v.name, ".ready_idle"}, 32'(ready_o), 32'd1);
            if (cyc == 1) check({v.name, ".ready_busy"}, 32'(ready_o), 32'd0);
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({v.name, ".ready_after"}, 32'(ready_o), 32'd1);
                break;
            end
            if (w_en_o) begin
                if (n_wr < 2) begin
                    wr_c[n_wr] = cyc; wr_a[n_wr] = w_addr_o; wr_d[n_wr] = w_data_o;
                end
                n_wr++;
            end
            if (r_v_o && r_ready_i) begin
                if (n_x == 0) begin
                    x_a = r_addr_o; x_d = r_data_o;
                end
                n_x++;
            end
            if (done_o) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk_i); #1;
            if (w_v_i) wv_cnt++;
            start_v_i = (cyc + 1 <= v.hold);
            w_v_i     = (cyc + 1 < 32) ? v.wv[cyc + 1] : 1'b1;
            r_ready_i = (cyc + 1 < 32) ? v.rr[cyc + 1] : 1'b1;
            w_data_i  = 8'(8'hAA + 8'h11 * wv_cnt);
        end
        start_v_i = 1'b0;
        check({v.name, ".done_cycle"}, 32'(done_cyc), 32'(v.e_done));
        check({v.name, ".done_pulses"}, 32'(n_done), 32'd1);
        check({v.name, ".n_writes"}, 32'(n_wr), 32'(v.e_nwr));
        if (v.e_nwr >= 1) begin
            check({v.name, ".wr0_cycle"}, 32'(wr_c[0]), 32'(v.e_c0));
            check({v.name, ".wr0_addr"}, 32'(wr_a[0]), 32'(v.e_a0));
            check({v.name, ".wr0_data"}, 32'(wr_d[0]), 32'(v.e_d0));
        end
        if (v.e_nwr >= 2) begin
            check({v.name, ".wr1_cycle"}, 32'(wr_c[1]), 32'(v.e_c1));
            check({v.name, ".wr1_addr"}, 32'(wr_a[1]), 32'(v.e_a1));
            check({v.name, ".wr1_data"}, 32'(wr_d[1]), 32'(v.e_d1));
        end
        check({v.name, ".n_xfers"}, 32'(n_x), 32'(v.e_nx));
        if (v.e_nx >= 1) begin
            check({v.name, ".x_addr"}, 32'(x_a), 32'(v.e_xa));
            check({v.name, ".x_data"}, 32'(x_d), 32'(v.e_xd));
        end
    endtask

    // Drives an op that stalls in ISSUE, then pulls reset low mid-cycle.
    task automatic reset_mid(input string name, input logic [3:0] op, input logic check_wen);
        int nd, nw, nr;
        nd = 0; nw = 0; nr = 0;
        @(posedge clk_i); #1;
        my_id_i = 2'd0; op_i = op; vl_i = 4'd8; mask_i = 2'b11;
        r0_data_i = 8'h11; w_data_i = 8'h77; w_v_i = 1'b0; r_ready_i = 1'b0;
        start_v_i = 1'b1;
        @(posedge clk_i); #1;          // cycle 1: a load issues element 0 here
        start_v_i = 1'b0;
        w_v_i = (op == 4'b1000);
        @(posedge clk_i); #1;          // cycle 2
        w_v_i = 1'b0;
        @(posedge clk_i); #1;          // cycle 3
        @(negedge clk_i);
        if (check_wen) check({name, ".wen_before"}, 32'(w_en_o), 32'd1);
        else           check({name, ".rv_before"}, 32'(r_v_o), 32'd1);
        #2 reset_ni = 1'b0;
        #1;
        check({name, ".wen_in_reset"}, 32'(w_en_o), 32'd0);
        check({name, ".rv_in_reset"}, 32'(r_v_o), 32'd0);
        @(negedge clk_i); #2 reset_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (done_o) nd++;
            if (w_en_o) nw++;
            if (r_v_o)  nr++;
        end
        check({name, ".no_done"}, 32'(nd), 32'd0);
        check({name, ".no_writes"}, 32'(nw + nr), 32'd0);
        check({name, ".ready_after"}, 32'(ready_o), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        //            name          op       id    vl     sc     r0     r1     r2     wv            rr            mask   hold nwr c0 a0 d0     c1 a1 d1     done nx xa xd
        vecs.push_back('{"add_vv",    4'b0000, 2'd1, 4'd8,  8'h00, 8'h03, 8'h05, 8'h00, 32'h0,        32'h0,        2'b11, 0, 2, 3, 1, 8'h08, 4, 5, 8'h08, 5, 0, 0, 8'h00});
        vecs.push_back('{"sub_vs",    4'b0101, 2'd1, 4'd8,  8'h0A, 8'h03, 8'h05, 8'h00, 32'h0,        32'h0,        2'b11, 0, 2, 3, 1, 8'hF9, 4, 5, 8'hF9, 5, 0, 0, 8'h00});
        vecs.push_back('{"fma_vv",    4'b0011, 2'd0, 4'd8,  8'h00, 8'd20,  8'd20,  8'd7,  32'h0,        32'h0,        2'b11, 0, 2, 3, 0, 8'h97, 4, 4, 8'h97, 5, 0, 0, 8'h00});
        vecs.push_back('{"and_vs",    4'b0110, 2'd3, 4'd8,  8'h3C, 8'hF3, 8'h00, 8'h00, 32'h0,        32'h0,        2'b11, 0, 2, 3, 3, 8'h30, 4, 7, 8'h30, 5, 0, 0, 8'h00});
        vecs.push_back('{"sub_vv",    4'b0001, 2'd2, 4'd8,  8'h00, 8'h03, 8'h05, 8'h00, 32'h0,        32'h0,        2'b11, 0, 2, 3, 2, 8'hFE, 4, 6, 8'hFE, 5, 0, 0, 8'h00});
        vecs.push_back('{"fma_vs",    4'b0111, 2'd0, 4'd8,  8'h03, 8'h55, 8'h99, 8'h01, 32'h0,        32'h0,        2'b11, 0, 2, 3, 0, 8'h00, 4, 4, 8'h00, 5, 0, 0, 8'h00});
        vecs.push_back('{"add_short", 4'b0000, 2'd3, 4'd6,  8'h00, 8'h80, 8'h80, 8'h00, 32'h0,        32'h0,        2'b11, 0, 1, 3, 3, 8'h00, 0, 0, 8'h00, 4, 0, 0, 8'h00});
        vecs.push_back('{"add_clamp", 4'b0000, 2'd2, 4'd15, 8'h00, 8'h01, 8'h02, 8'h00, 32'h0,        32'h0,        2'b11, 0, 2, 3, 2, 8'h03, 4, 6, 8'h03, 5, 0, 0, 8'h00});
        vecs.push_back('{"load",      4'b1000, 2'd0, 4'd8,  8'h00, 8'h00, 8'h00, 8'h00, 32'hFFFFFFF8, 32'h0,        2'b11, 0, 2, 5, 0, 8'hAA, 6, 4, 8'hBB, 7, 0, 0, 8'h00});
        vecs.push_back('{"store_stl", 4'b1001, 2'd2, 4'd5,  8'h00, 8'h5A, 8'h00, 8'h00, 32'h0,        32'hFFFFFFF0, 2'b11, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 7, 1, 2, 8'h5A});
        vecs.push_back('{"store_all", 4'b1001, 2'd1, 4'd8,  8'h00, 8'h33, 8'h00, 8'h00, 32'h0,        32'hFFFFFFFF, 2'b11, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 5, 2, 1, 8'h33});
        vecs.push_back('{"zero_cnt",  4'b0000, 2'd2, 4'd2,  8'h00, 8'h01, 8'h01, 8'h00, 32'h0,        32'h0,        2'b11, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h00});
        vecs.push_back('{"vl_zero",   4'b0000, 2'd0, 4'd0,  8'h00, 8'h01, 8'h01, 8'h00, 32'h0,        32'h0,        2'b11, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h00});
        vecs.push_back('{"nop",       4'b1100, 2'd0, 4'd8,  8'h00, 8'h01, 8'h01, 8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h00});
        vecs.push_back('{"add_busy",  4'b0000, 2'd1, 4'd8,  8'h00, 8'h03, 8'h05, 8'h00, 32'h0,        32'h0,        2'b11, 2, 2, 3, 1, 8'h08, 4, 5, 8'h08, 5, 0, 0, 8'h00});
`ifdef VLANE_MASK_EN
        vecs.push_back('{"add_mask",  4'b0000, 2'd0, 4'd8,  8'h00, 8'h03, 8'h05, 8'h00, 32'h0,        32'h0,        2'b10, 0, 1, 4, 4, 8'h08, 0, 0, 8'h00, 5, 0, 0, 8'h00});
        vecs.push_back('{"store_msk", 4'b1001, 2'd1, 4'd8,  8'h00, 8'h44, 8'h00, 8'h00, 32'h0,        32'hFFFFFFFF, 2'b10, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 5, 1, 5, 8'h44});
`endif

        reset_ni = 1'b0; start_v_i = 1'b0; my_id_i = '0; op_i = '0; vl_i = '0;
        scalar_i = '0; mask_i = 2'b11; w_data_i = '0; w_v_i = 1'b0; r_ready_i = 1'b0;
        r0_data_i = '0; r1_data_i = '0; r2_data_i = '0;
        #3;
        check("rst.ready", 32'(ready_o), 32'd1);
        check("rst.w_en", 32'(w_en_o), 32'd0);
        check("rst.r_v", 32'(r_v_o), 32'd0);
        check("rst.done", 32'(done_o), 32'd0);
        #9 reset_ni = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        reset_mid("rst_load", 4'b1000, 1'b1);
        reset_mid("rst_store", 4'b1001, 1'b0);

        // Lane still works normally after a mid-op reset.
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

endmodule
